// File: rtl/ps2_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scan_decoder_if
//  Description : Byte-in / character-out bundle of the PS/2 scancode decoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_scan_decoder_if #(
    parameter int FIFO_AW = 3
);
    logic [7:0]       scan_code;
    logic             scan_valid;
    logic [7:0]       ascii_data;
    logic             ascii_valid;
    logic             ascii_ready;
    logic [FIFO_AW:0] fifo_count;
    logic             overflow;
    logic             clr_overflow;
    logic             mod_shift;
    logic             mod_ctrl;
    logic             mod_alt;
    logic             caps_lock;

    modport master (
        output scan_code, scan_valid, ascii_ready, clr_overflow,
        input  ascii_data, ascii_valid, fifo_count, overflow,
        input  mod_shift, mod_ctrl, mod_alt, caps_lock
    );

    modport slave (
        input  scan_code, scan_valid, ascii_ready, clr_overflow,
        output ascii_data, ascii_valid, fifo_count, overflow,
        output mod_shift, mod_ctrl, mod_alt, caps_lock
    );
endinterface
`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scan_decoder
//  Description : Prefix-aware PS/2 set-2 decoder with modifiers and char FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_scan_decoder #(
    parameter int FIFO_AW       = 3,
    parameter bit EMIT_BREAK    = 1'b0,
    parameter bit DROP_UNMAPPED = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    ps2_scan_decoder_if.slave bus
);
    localparam int unsigned      C_DEPTH_N = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] C_DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [7:0]       C_SC_EXT  = 8'hE0;
    localparam logic [7:0]       C_SC_BRK  = 8'hF0;

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_BRK     = 2'd1;
    localparam logic [1:0] C_ST_EXT     = 2'd2;
    localparam logic [1:0] C_ST_EXT_BRK = 2'd3;

    // Result: [8] mapped, [7] letter (code holds uppercase), [6:0] code
    function automatic logic [8:0] map_key(input logic [7:0] sc, input logic ext,
                                           input logic shifted);
        logic [8:0] r;
        r = 9'd0;
        case (sc)
            8'h75: r = {2'b10, 7'h02};
            8'h74: r = {2'b10, 7'h03};
            8'h6B: r = {2'b10, 7'h04};
            8'h72: r = {2'b10, 7'h05};
            default: begin
                if (!ext) begin
                    case (sc)
                        8'h1C: r = {2'b11, 7'h41};  8'h32: r = {2'b11, 7'h42};
                        8'h21: r = {2'b11, 7'h43};  8'h23: r = {2'b11, 7'h44};
                        8'h24: r = {2'b11, 7'h45};  8'h2B: r = {2'b11, 7'h46};
                        8'h34: r = {2'b11, 7'h47};  8'h33: r = {2'b11, 7'h48};
                        8'h43: r = {2'b11, 7'h49};  8'h3B: r = {2'b11, 7'h4A};
                        8'h42: r = {2'b11, 7'h4B};  8'h4B: r = {2'b11, 7'h4C};
                        8'h3A: r = {2'b11, 7'h4D};  8'h31: r = {2'b11, 7'h4E};
                        8'h44: r = {2'b11, 7'h4F};  8'h4D: r = {2'b11, 7'h50};
                        8'h15: r = {2'b11, 7'h51};  8'h2D: r = {2'b11, 7'h52};
                        8'h1B: r = {2'b11, 7'h53};  8'h2C: r = {2'b11, 7'h54};
                        8'h3C: r = {2'b11, 7'h55};  8'h2A: r = {2'b11, 7'h56};
                        8'h1D: r = {2'b11, 7'h57};  8'h22: r = {2'b11, 7'h58};
                        8'h35: r = {2'b11, 7'h59};  8'h1A: r = {2'b11, 7'h5A};
                        8'h45: r = {2'b10, shifted ? 7'h29 : 7'h30};
                        8'h16: r = {2'b10, shifted ? 7'h21 : 7'h31};
                        8'h1E: r = {2'b10, shifted ? 7'h40 : 7'h32};
                        8'h26: r = {2'b10, shifted ? 7'h23 : 7'h33};
                        8'h25: r = {2'b10, shifted ? 7'h24 : 7'h34};
                        8'h2E: r = {2'b10, shifted ? 7'h25 : 7'h35};
                        8'h36: r = {2'b10, shifted ? 7'h5E : 7'h36};
                        8'h3D: r = {2'b10, shifted ? 7'h26 : 7'h37};
                        8'h3E: r = {2'b10, shifted ? 7'h2A : 7'h38};
                        8'h46: r = {2'b10, shifted ? 7'h28 : 7'h39};
                        8'h41: r = {2'b10, shifted ? 7'h3C : 7'h2C};
                        8'h49: r = {2'b10, shifted ? 7'h3E : 7'h2E};
                        8'h4E: r = {2'b10, shifted ? 7'h5F : 7'h2D};
                        8'h29: r = {2'b10, 7'h20};
                        8'h5A: r = {2'b10, 7'h0D};
                        8'h66: r = {2'b10, 7'h08};
                        default: r = 9'd0;
                    endcase
                end
            end
        endcase
        return r;
    endfunction

    logic [1:0]         state_q, state_d;
    logic               lshift_q, lshift_d, rshift_q, rshift_d;
    logic               ctrl_q, ctrl_d, alt_q, alt_d;
    logic               caps_q, caps_d, caps_held_q, caps_held_d;
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q;
    logic [7:0]         mem_q [C_DEPTH_N];

    logic       w_make, w_break, w_ext, w_prefix;
    logic       w_shift, w_is_mod, w_is_caps, w_push, w_pop, w_full, w_wr, w_drop;
    logic [8:0] w_key;
    logic [6:0] w_code;
    logic [7:0] w_push_data;

    assign w_prefix = (bus.scan_code == C_SC_EXT) || (bus.scan_code == C_SC_BRK);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= C_ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state; a prefix arriving where a key byte is due restarts the sequence
    always_comb begin
        state_d = state_q;
        if (bus.scan_valid) begin
            case (state_q)
                C_ST_IDLE:
                    if (bus.scan_code == C_SC_EXT)      state_d = C_ST_EXT;
                    else if (bus.scan_code == C_SC_BRK) state_d = C_ST_BRK;
                C_ST_EXT:
                    if (bus.scan_code == C_SC_BRK)      state_d = C_ST_EXT_BRK;
                    else                                state_d = C_ST_IDLE;
                default:
                    if (bus.scan_code == C_SC_EXT)      state_d = C_ST_EXT;
                    else if (bus.scan_code == C_SC_BRK) state_d = C_ST_BRK;
                    else                                state_d = C_ST_IDLE;
            endcase
        end
    end

    // Key events
    always_comb begin
        w_make  = 1'b0;
        w_break = 1'b0;
        w_ext   = 1'b0;
        if (bus.scan_valid) begin
            case (state_q)
                C_ST_IDLE: w_make = !w_prefix;
                C_ST_EXT: begin
                    w_make = (bus.scan_code != C_SC_BRK);
                    w_ext  = 1'b1;
                end
                C_ST_BRK:  w_break = !w_prefix;
                default: begin
                    w_break = !w_prefix;
                    w_ext   = 1'b1;
                end
            endcase
        end
    end

    assign w_shift   = lshift_q | rshift_q;
    assign w_is_caps = !w_ext && (bus.scan_code == 8'h58);
    assign w_is_mod  = w_is_caps || (bus.scan_code == 8'h14) || (bus.scan_code == 8'h11) ||
                       (!w_ext && ((bus.scan_code == 8'h12) || (bus.scan_code == 8'h59)));
    assign w_key     = map_key(bus.scan_code, w_ext, w_shift);

    always_comb begin
        w_code = w_key[6:0];
        if (w_key[7]) begin
            if (ctrl_q)                 w_code = w_key[6:0] & 7'h1F;
            else if (!(w_shift ^ caps_q)) w_code = w_key[6:0] | 7'h20;
        end
    end

    assign w_push = !w_is_mod &&
                    ((w_make && (w_key[8] || (!w_ext && !DROP_UNMAPPED))) ||
                     (w_break && EMIT_BREAK && w_key[8]));
    assign w_push_data = w_break ? {1'b1, w_code} : (w_key[8] ? {1'b0, w_code} : 8'h7F);

    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        ctrl_d      = ctrl_q;
        alt_d       = alt_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        if (w_make || w_break) begin
            if (!w_ext && bus.scan_code == 8'h12) lshift_d = w_make;
            if (!w_ext && bus.scan_code == 8'h59) rshift_d = w_make;
            if (bus.scan_code == 8'h14)           ctrl_d   = w_make;
            if (bus.scan_code == 8'h11)           alt_d    = w_make;
            if (w_is_caps) begin
                if (w_make && !caps_held_q) caps_d = !caps_q;
                caps_held_d = w_make;
            end
        end
    end

    // FIFO control; a pop in the same cycle frees the slot for a write at full
    assign w_pop  = (count_q != '0) && bus.ascii_ready;
    assign w_full = (count_q == C_DEPTH);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_comb begin
        count_d = count_q;
        if (w_wr && !w_pop)      count_d = count_q + (FIFO_AW+1)'(1);
        else if (!w_wr && w_pop) count_d = count_q - (FIFO_AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            ctrl_q      <= 1'b0;
            alt_q       <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            ctrl_q      <= ctrl_d;
            alt_q       <= alt_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            count_q     <= count_d;
            if (w_wr)  wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (w_pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            if (w_drop)                 ovf_q <= 1'b1;
            else if (bus.clr_overflow)  ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q] <= w_push_data;
    end

    assign bus.ascii_valid = (count_q != '0);
    assign bus.ascii_data  = bus.ascii_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.fifo_count  = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.mod_shift   = w_shift;
    assign bus.mod_ctrl    = ctrl_q;
    assign bus.mod_alt     = alt_q;
    assign bus.caps_lock   = caps_q;
endmodule
`default_nettype wire

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Stateful PS/2 set-2 scancode decoder for the `wb_ps2` keyboard path. It replaces the flat per-byte lookup with a prefix-aware FSM that tracks make/break (`F0`) and extended (`E0`) prefixes. It also tracks modifier and Caps Lock state, produces case-correct ASCII and control codes, and buffers characters in a parametrised FIFO with a valid/ready handshake toward the Wishbone register front end.

## Interface
- `FIFO_AW`, 3: FIFO address width; depth = 2**FIFO_AW entries (legal 1..6).
- `EMIT_BREAK`, 0: 1 = also push a character on key release, with bit 7 set.
- `DROP_UNMAPPED`, 1: 1 = discard unmapped make codes; 0 = push `7F`.
- `clk` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `scan_code` in 8: received PS/2 byte, sampled when `scan_valid`=1.
- `scan_valid` in 1: one-cycle strobe per received byte; back-to-back strobes allowed.
- `ascii_data` out 8: FIFO head; [6:0] = code, [7] = break flag; 0 when empty.
- `ascii_valid` out 1: FIFO not empty.
- `ascii_ready` in 1: consumer pops the head when `ascii_valid` & `ascii_ready`.
- `fifo_count` out FIFO_AW+1: number of stored entries.
- `overflow` out 1: sticky; set when a character is dropped because the FIFO is full.
- `clr_overflow` in 1: synchronous clear of `overflow`; a same-cycle set wins.
- `mod_shift`, `mod_ctrl`, `mod_alt`, `caps_lock` out 1 each: live modifier state.

## Operation
- Prefix FSM states: IDLE, BRK (after `F0`), EXT (after `E0`), EXT_BRK (after `E0 F0`). It advances only on `scan_valid`.
  - IDLE: `E0` goes to EXT; `F0` goes to BRK; any other byte is a make and stays in IDLE.
  - EXT: `F0` goes to EXT_BRK; any other byte is an extended make and returns to IDLE.
  - BRK and EXT_BRK: the next byte is a release and returns to IDLE.
  - `E0` or `F0` received in BRK or EXT_BRK resets the FSM to EXT or BRK respectively (resync).
- Modifiers:
  - Left shift `12` and right shift `59` are tracked separately; `mod_shift` = OR of the two.
  - Ctrl `14` is tracked with or without `E0`; Alt `11` is tracked with or without `E0`.
  - Make sets the modifier; release clears it. Modifier keys never push a character.
- Caps Lock `58`: toggles `caps_lock` on make only when not already held. A held flag blocks typematic repeats; release clears the held flag.
- Make-code mapping:
  - Letters (`1C`=A … `1A`=Z, US set-2 positions): uppercase `41`–`5A` when `mod_shift` XOR `caps_lock`, else lowercase `61`–`7A`.
  - Digits `45`,`16`,`1E`,`26`,`25`,`2E`,`36`,`3D`,`3E`,`46`: `0`–`9` unshifted. Shifted: `)!@#$%^&*(`.
  - `41` gives `,` / `<`; `49` gives `.` / `>`; `4E` gives `-` / `_` (unshifted / shifted).
  - `29` gives `20`; `5A` gives `0D`; `66` gives `08`.
  - `75`/`74`/`6B`/`72` give `02`/`03`/`04`/`05`, with or without `E0`.
  - When `mod_ctrl`=1 and the key is a letter, push uppercase code AND `1F` (Ctrl+A gives `01`).
  - Any other `E0`-prefixed make is discarded regardless of `DROP_UNMAPPED`.
- Release handling: with `EMIT_BREAK`=1, a mapped release pushes {1, code}, using the same mapping with current modifiers. With `EMIT_BREAK`=0, releases never push.
- FIFO write rules:
  - A write is accepted when not full, or when a pop occurs in the same cycle.
  - A dropped write sets `overflow`; FIFO contents are unchanged.
- Pointers are FIFO_AW bits and wrap modulo depth. The count is FIFO_AW+1 bits, so full is indicated by count = depth.

## Timing
- Reset (asynchronous, while `reset_n`=0), all outputs go to 0:
  - FSM to IDLE, all modifiers and `caps_lock` cleared.
  - FIFO emptied: `ascii_valid`=0, `ascii_data`=0, `fifo_count`=0; `overflow`=0.
  - Buffered characters and a partial prefix sequence are lost.
- Decode is combinational from `scan_code` and registered state. A byte strobed at edge N is in the FIFO after edge N; with the FIFO previously empty, `ascii_valid`=1 in cycle N+1 (1-cycle latency).
- Modifier, caps and FSM updates take effect at the same edge. A byte at edge N+1 uses the state produced by edge N.
- FIFO is first-word fall-through: the head is visible whenever `ascii_valid`=1. A pop at edge M exposes the next entry in cycle M+1.
- Simultaneous push and pop: `fifo_count` is unchanged; this is legal at full and at empty+1.
- `ascii_ready` while empty has no effect. `ascii_valid`/`ascii_data` may change only after a push into an empty FIFO or after a pop.

## Test plan
- Reset, then strobe `1C`: `ascii_data`=`61`, `ascii_valid`=1 one cycle later. Then strobe `F0 1C` (EMIT_BREAK=0): no new entry, `fifo_count`=1.
- Strobe `12`, `1E`, `F0`, `12`, `1E`: FIFO holds `40` then `32`; `mod_shift` returns to 0.
- Strobe `58`, `58`, `F0`, `58`, `15`: `caps_lock` toggles once (second make ignored), then `51` is pushed. Next, with `E0 14` held and `23` pressed: `04` is pushed.
- Strobe `E0 75`, then `E0 F0 75`, with EMIT_BREAK=1: FIFO holds `02` then `82`.
- Depth 8, `ascii_ready`=0, strobe 9 letters: `fifo_count`=8, `overflow`=1, and the 9th letter is absent. Then raise `ascii_ready` coincident with a 10th strobe: count stays 8 and the 10th letter is stored.
- Strobe `E0`, assert `reset_n`=0 mid-sequence, release, strobe `75`: FSM was cleared, `02` is pushed, no stale state.
